// File: rtl/mu_pair_arbiter.sv
// Round-robin arbiter sharing a 1:2 width adapter between two word streams.
// Grants cover even-length bursts; an odd frame end is completed with a pad.
module mu_pair_arbiter #(
  parameter int            IW        = 32,
  parameter int            BURST_LEN = 16,
  parameter logic [IW-1:0] PAD_WORD  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic [IW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic [IW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          m_src,
  output logic          busy
);

  localparam int CW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    PAD   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_gnt;
  logic          r_prio;
  logic [CW-1:0] r_cnt;

  logic          w_sel_valid;
  logic          w_sel_last;
  logic [IW-1:0] w_sel_data;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_full;
  logic          w_end;
  logic          w_hs;

  always_comb begin
    w_sel_valid = r_gnt ? s1_valid : s0_valid;
    w_sel_last  = r_gnt ? s1_last  : s0_last;
    w_sel_data  = r_gnt ? s1_data  : s0_data;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_full      = (w_cnt_nxt == CW'(BURST_LEN));
    // End the grant only where the pair count is even.
    w_end       = w_full | (w_sel_last & ~w_cnt_nxt[0]);
    w_hs        = (r_state == BURST) & w_sel_valid & m_ready;
  end

  always_comb begin
    m_data   = '0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_src    = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    busy     = (r_state != IDLE);
    unique case (r_state)
      BURST: begin
        m_data   = w_sel_data;
        m_valid  = w_sel_valid;
        m_last   = w_sel_valid & w_end;
        m_src    = r_gnt;
        s0_ready = ~r_gnt & m_ready;
        s1_ready = r_gnt & m_ready;
      end
      PAD: begin
        m_data  = PAD_WORD;
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_src   = r_gnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s0_valid | s1_valid) begin
            r_gnt   <= (s0_valid & s1_valid) ? r_prio : s1_valid;
            r_cnt   <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_hs) begin
            r_cnt <= w_cnt_nxt;
            if (w_end) begin
              r_state <= IDLE;
              r_prio  <= ~r_gnt;
            end else if (w_sel_last) begin
              r_state <= PAD;
            end
          end
        end
        PAD: begin
          if (m_ready) begin
            r_state <= IDLE;
            r_prio  <= ~r_gnt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mu_pair_arbiter.md
# mu_pair_arbiter

- Round-robin arbiter that shares one 1:2 width adapter (`IW` → `2*IW`) between two `IW`-bit pixel/word streams.
- Grants are held for whole bursts of even length, so a packed `2*IW` output word never mixes data from both sources.
- When a source ends a frame on an odd word, the arbiter inserts one pad word to complete the pair.
- Sits directly upstream of the width adapter in the frame-buffer write path; `m_src` travels alongside the data so downstream logic can route it to the right buffer.

## Interface

Parameters:
- `IW`, 32, word width of the source and master streams.
- `BURST_LEN`, 16, maximum words per grant; must be even and ≥2.
- `PAD_WORD`, 0 (`IW` bits), data value driven on an inserted pad word.
- Local parameter: `CW = $clog2(BURST_LEN)+1`, width of the burst counter.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s0_data` in `IW`: source 0 data.
- `s0_valid` in 1: source 0 valid.
- `s0_last` in 1: source 0 end-of-frame, qualified by valid.
- `s0_ready` out 1: source 0 ready.
- `s1_data`, `s1_valid`, `s1_last`, `s1_ready`: same as source 0, for source 1.
- `m_data` out `IW`: data to the width adapter write port.
- `m_valid` out 1: master valid.
- `m_ready` in 1: master ready, from the adapter's `wr_ready`.
- `m_last` out 1: final word of the current grant.
- `m_src` out 1: index of the source owning the current word.
- `busy` out 1: a grant is active (state is not IDLE).

## Operation

State machine: IDLE, BURST, PAD. Registers: `state`, `gnt` (1 bit), `cnt` (`CW` bits), `prio` (1 bit).

- **IDLE**
  - All outputs are inactive: `m_valid=0`, `s*_ready=0`, `m_data=0`, `m_last=0`.
  - If any `sN_valid` is high: `gnt` ← requester. If both request, `gnt` ← `prio`; if only one requests, it wins regardless of `prio`.
  - `cnt` ← 0, state → BURST.
- **BURST**
  - `m_data`/`m_valid` are muxed combinationally from source `gnt`.
  - `s[gnt]_ready = m_ready`; the other source's ready is held 0.
  - On each handshake (`m_valid & m_ready`), `cnt` ← `cnt+1`.
  - Handshake with `s[gnt]_last=1` and `cnt+1` even: state → IDLE, `prio` ← `~gnt`.
  - Handshake with `s[gnt]_last=1` and `cnt+1` odd: state → PAD.
  - Handshake with `cnt+1 == BURST_LEN`: state → IDLE, `prio` ← `~gnt`.
  - `m_last=1` on the word that causes the IDLE transition. It is 0 on a word that leads into PAD.
- **PAD**
  - Drives `m_valid=1`, `m_data=PAD_WORD`, `m_last=1`, `m_src=gnt`.
  - Both `s*_ready` are 0.
  - On `m_ready`: state → IDLE, `prio` ← `~gnt`.
- `m_src = gnt` in BURST and PAD, 0 in IDLE. `busy = (state != IDLE)`.
- Dropping `s[gnt]_valid` mid-burst does not release the grant; the arbiter waits. Bursts end only on last, pad completion, or count.
- Invariant: every grant delivers an even number of master handshakes (including any pad), so the adapter is empty (no half-filled pair) at each return to IDLE.

## Timing

- **Reset** (`rst_n` low, asynchronous):
  - `state`=IDLE, `gnt`=0, `cnt`=0, `prio`=0.
  - Outputs: `m_valid=0`, `m_last=0`, `m_src=0`, `m_data=0`, `s0_ready=s1_ready=0`, `busy=0`.
- **Reset mid-burst:** the burst is abandoned immediately with no pad. The width adapter must be reset in the same domain.
- **Arbitration latency:** a request seen in IDLE at edge N gives the first transfer possible in cycle N+1. There is exactly one bubble cycle between grants.
- **Throughput:** with both sources saturated and `m_ready=1`, each source alternates bursts of `BURST_LEN` words; utilisation is `BURST_LEN/(BURST_LEN+1)`.
- **Combinational paths:** `s*_valid`/`data`/`last` → `m_*`, and `m_ready` → `s*_ready`. There is no registered path in the datapath.
- **Simultaneous events:**
  - `last` on the `BURST_LEN`-th word: this is a normal end with the IDLE transition and no pad.
  - The counter check uses `cnt+1`, so it never wraps.
- **Pad with backpressure:** `m_ready=0` during PAD holds PAD with data stable.

## Test plan

1. **Reset:** assert `rst_n`=0 mid-burst → all outputs are 0 on the same cycle. After release, `busy=0` and `prio=0`.
2. **Both sources saturated, `BURST_LEN=4`, `m_ready=1`:** expect m_src 0,0,0,0, bubble, 1,1,1,1, bubble, 0,…
   - `m_last` is set on every 4th word.
   - The adapter output never mixes sources.
3. **Source 1 alone sends 3 words with `last` on the third:**
   - Expect 3 words with `m_src=1`, then the pad word (`PAD_WORD`, `m_last=1`), then IDLE.
   - The adapter emits 2 packed words.
4. **Source 0 sends 2 words with `last` on the second:** expect no pad, `m_last=1` on word 2, next grant to source 1 if it is requesting.
5. **Random `m_ready` backpressure and random source valid gaps:**
   - Data order is preserved per source.
   - The non-granted ready stays 0.
   - Every grant totals an even handshake count.
   - No word is lost or duplicated; check against a scoreboard.
6. **Only source 0 requesting, `prio`=1:** source 0 is still granted after the one-cycle arbitration bubble.
